// File: rtl/maze_pkg.sv
// Shared definitions for the maze solver and its downstream consumers.
//   MV_*            : 2-bit move codes emitted by the solver
//   state_t         : path_tracker controller states
//   COORD_W         : default coordinate width (5-bit maze addressing)
//   mv_is_x/mv_is_neg: decode a move into axis and direction
package maze_pkg;

  localparam int COORD_W = 5;

  localparam logic [1:0] MV_UP    = 2'b00;  // y - 1
  localparam logic [1:0] MV_RIGHT = 2'b01;  // x + 1
  localparam logic [1:0] MV_LEFT  = 2'b10;  // x - 1
  localparam logic [1:0] MV_DOWN  = 2'b11;  // y + 1

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_REPLAY  = 3'd2,
    ST_DONE    = 3'd3,
    ST_FAIL    = 3'd4
  } state_t;

  // True when the move changes x (RIGHT/LEFT), false when it changes y.
  function automatic logic mv_is_x(input logic [1:0] mv);
    return (mv == MV_RIGHT) || (mv == MV_LEFT);
  endfunction

  // True when the move decrements its coordinate (UP/LEFT).
  function automatic logic mv_is_neg(input logic [1:0] mv);
    return (mv == MV_UP) || (mv == MV_LEFT);
  endfunction

endpackage

// File: rtl/move_buf.sv
// Path buffer: DEPTH x 2-bit register file written in order, with an
// independent read index used during replay.
//   clk, rst   : clock, asynchronous active-low reset (pointers only)
//   clear      : synchronous return of count and read index to zero
//   wr_en      : append wr_data (ignored while full)
//   rd_adv     : advance the read index by one
//   count      : number of stored moves (0..DEPTH)
//   rd_idx     : current read index
//   rd_data    : move stored at rd_idx (combinational from storage)
//   full       : count == DEPTH
module move_buf #(
  parameter int DEPTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   wr_en,
  input  logic [1:0]             wr_data,
  input  logic                   rd_adv,
  output logic [$clog2(DEPTH):0] count,
  output logic [$clog2(DEPTH):0] rd_idx,
  output logic [1:0]             rd_data,
  output logic                   full
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE_L   = (AW + 1)'(1);

  logic [1:0]  mem_r [DEPTH];
  logic [AW:0] count_r;
  logic [AW:0] rd_idx_r;
  logic        wr_ok_s;

  assign full    = (count_r == DEPTH_L);
  assign wr_ok_s = wr_en && !full;
  assign count   = count_r;
  assign rd_idx  = rd_idx_r;
  // rd_idx == DEPTH only occurs after the last move has been consumed,
  // so the wrapped index is never used for a real step.
  assign rd_data = mem_r[rd_idx_r[AW-1:0]];

  // Move storage; contents are don't-care after reset so no reset here.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_r[count_r[AW-1:0]] <= wr_data;
    end
  end

  // Write count doubles as the write pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (wr_ok_s) begin
      count_r <= count_r + ONE_L;
    end
  end

  // Replay read index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_idx_r <= '0;
    end else if (clear) begin
      rd_idx_r <= '0;
    end else if (rd_adv) begin
      rd_idx_r <= rd_idx_r + ONE_L;
    end
  end

endmodule

// File: rtl/path_tracker.sv
// Captures the solver's move stream and replays it as paced absolute
// (x, y) coordinates over a valid/ready handshake.
//   clk, rst                 : clock, asynchronous active-low reset
//   move_in, move_valid      : move stream from the solver
//   solved, failed           : solver outcome (level or pulse)
//   clear                    : leave DONE/FAIL and start over
//   pos_x, pos_y, pos_valid  : offered coordinate; pos_ready accepts it
//   path_len                 : number of stored moves
//   busy, replay_done, fail_out : state indications
//   overflow, err_oob        : sticky error flags
module path_tracker
  import maze_pkg::*;
#(
  parameter int DEPTH    = 64,
  parameter int W        = COORD_W,
  parameter int START_X  = 0,
  parameter int START_Y  = 0,
  parameter int STEP_DIV = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             move_in,
  input  logic                   move_valid,
  input  logic                   solved,
  input  logic                   failed,
  input  logic                   clear,
  output logic [W-1:0]           pos_x,
  output logic [W-1:0]           pos_y,
  output logic                   pos_valid,
  input  logic                   pos_ready,
  output logic [$clog2(DEPTH):0] path_len,
  output logic                   busy,
  output logic                   replay_done,
  output logic                   fail_out,
  output logic                   overflow,
  output logic                   err_oob
);

  localparam int           AW     = $clog2(DEPTH);
  localparam int           CW     = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [W-1:0] X0     = W'(START_X);
  localparam logic [W-1:0] Y0     = W'(START_Y);
  localparam logic [W-1:0] CMAX   = {W{1'b1}};
  localparam logic [W-1:0] ONE_W  = W'(1);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  state_t        state_r, state_nx;
  logic [W-1:0]  pos_x_r, pos_y_r;
  logic [W-1:0]  step_x_s, step_y_s;
  logic          pos_valid_r;
  logic [CW-1:0] pace_r;
  logic          busy_r, replay_done_r, fail_out_r;
  logic          overflow_r, err_oob_r;

  logic          capturing_s, wr_en_s, ovf_evt_s, clear_s;
  logic          fire_s, last_s, oob_s, rd_adv_s, enter_replay_s;
  logic [AW:0]   count_s, rd_idx_s;
  logic [1:0]    rd_data_s;
  logic          full_s;

  move_buf #(.DEPTH(DEPTH)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear_s),
    .wr_en   (wr_en_s),
    .wr_data (move_in),
    .rd_adv  (rd_adv_s),
    .count   (count_s),
    .rd_idx  (rd_idx_s),
    .rd_data (rd_data_s),
    .full    (full_s)
  );

  assign capturing_s    = (state_r == ST_IDLE) || (state_r == ST_CAPTURE);
  assign wr_en_s        = capturing_s && move_valid;
  assign ovf_evt_s      = wr_en_s && full_s;
  assign clear_s        = ((state_r == ST_DONE) || (state_r == ST_FAIL)) && clear;
  assign fire_s         = (state_r == ST_REPLAY) && pos_valid_r && pos_ready;
  // Coordinate index equals the read index; index path_len is the final cell.
  assign last_s         = (rd_idx_s == count_s);
  assign rd_adv_s       = fire_s && !last_s && !oob_s;
  assign enter_replay_s = (state_r != ST_REPLAY) && (state_nx == ST_REPLAY);

  // Next coordinate from the move at the read index, with range check.
  always_comb begin
    step_x_s = pos_x_r;
    step_y_s = pos_y_r;
    oob_s    = 1'b0;
    if (mv_is_x(rd_data_s)) begin
      if (mv_is_neg(rd_data_s)) begin
        if (pos_x_r == '0) oob_s = 1'b1;
        else               step_x_s = pos_x_r - ONE_W;
      end else begin
        if (pos_x_r == CMAX) oob_s = 1'b1;
        else                 step_x_s = pos_x_r + ONE_W;
      end
    end else begin
      if (mv_is_neg(rd_data_s)) begin
        if (pos_y_r == '0) oob_s = 1'b1;
        else               step_y_s = pos_y_r - ONE_W;
      end else begin
        if (pos_y_r == CMAX) oob_s = 1'b1;
        else                 step_y_s = pos_y_r + ONE_W;
      end
    end
  end

  // Next-state logic; failed has priority over solved.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      ST_IDLE: begin
        if (failed)          state_nx = ST_FAIL;
        else if (solved)     state_nx = ST_REPLAY;
        else if (move_valid) state_nx = ST_CAPTURE;
        else                 state_nx = ST_IDLE;
      end
      ST_CAPTURE: begin
        if (failed)      state_nx = ST_FAIL;
        else if (solved) state_nx = ST_REPLAY;
        else             state_nx = ST_CAPTURE;
      end
      ST_REPLAY: begin
        if (fire_s && last_s)     state_nx = ST_DONE;
        else if (fire_s && oob_s) state_nx = ST_FAIL;
        else                      state_nx = ST_REPLAY;
      end
      ST_DONE: begin
        if (clear) state_nx = ST_IDLE;
        else       state_nx = ST_DONE;
      end
      ST_FAIL: begin
        if (clear) state_nx = ST_IDLE;
        else       state_nx = ST_FAIL;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= ST_IDLE;
    else      state_r <= state_nx;
  end

  // Registered state indications derived from the next state so they
  // line up with the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_r        <= 1'b0;
      replay_done_r <= 1'b0;
      fail_out_r    <= 1'b0;
    end else begin
      busy_r        <= (state_nx == ST_CAPTURE) || (state_nx == ST_REPLAY);
      replay_done_r <= (state_nx == ST_DONE);
      fail_out_r    <= (state_nx == ST_FAIL);
    end
  end

  // Sticky error flags, cleared only by clear or reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_r <= 1'b0;
      err_oob_r  <= 1'b0;
    end else if (clear_s) begin
      overflow_r <= 1'b0;
      err_oob_r  <= 1'b0;
    end else begin
      if (ovf_evt_s) overflow_r <= 1'b1;
      if (fire_s && !last_s && oob_s) err_oob_r <= 1'b1;
    end
  end

  // Replay position and pacing. pace_r counts down the idle gap after a
  // handshake; valid reasserts when it passes 1. Entry into REPLAY loads
  // 1 so the start cell appears one cycle after the state change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos_x_r     <= X0;
      pos_y_r     <= Y0;
      pos_valid_r <= 1'b0;
      pace_r      <= '0;
    end else if (clear_s || enter_replay_s) begin
      pos_x_r     <= X0;
      pos_y_r     <= Y0;
      pos_valid_r <= 1'b0;
      pace_r      <= clear_s ? '0 : ONE_C;
    end else if (state_r == ST_REPLAY) begin
      if (fire_s) begin
        if (last_s || oob_s) begin
          pos_valid_r <= 1'b0;
          pace_r      <= '0;
        end else begin
          pos_x_r <= step_x_s;
          pos_y_r <= step_y_s;
          if (STEP_DIV == 1) begin
            pos_valid_r <= 1'b1;
            pace_r      <= '0;
          end else begin
            pos_valid_r <= 1'b0;
            pace_r      <= CW'(STEP_DIV - 1);
          end
        end
      end else if (!pos_valid_r && (pace_r != '0)) begin
        pace_r <= pace_r - ONE_C;
        if (pace_r == ONE_C) pos_valid_r <= 1'b1;
      end else begin
        pos_valid_r <= pos_valid_r;
      end
    end else begin
      pos_valid_r <= 1'b0;
      pace_r      <= '0;
    end
  end

  assign pos_x       = pos_x_r;
  assign pos_y       = pos_y_r;
  assign pos_valid   = pos_valid_r;
  assign path_len    = count_s;
  assign busy        = busy_r;
  assign replay_done = replay_done_r;
  assign fail_out    = fail_out_r;
  assign overflow    = overflow_r;
  assign err_oob     = err_oob_r;

endmodule

// File: tb/tb_path_tracker.sv
// Self-checking bench for path_tracker: table-driven paths, hand-written
// timing sequences and randomized paths with random back-pressure, all
// compared against a coordinate-list reference model.
module tb_path_tracker;

  localparam int DEPTH = 64;
  localparam int W     = 5;
  localparam int STEP  = 4;
  localparam int MAXC  = 31;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [1:0]             move_in = 2'b00;
  logic                   move_valid = 1'b0, solved = 1'b0, failed = 1'b0, clear = 1'b0;
  logic                   pos_ready = 1'b0;
  logic [W-1:0]           pos_x, pos_y;
  logic                   pos_valid, busy, replay_done, fail_out, overflow, err_oob;
  logic [$clog2(DEPTH):0] path_len;

  path_tracker #(.DEPTH(DEPTH), .W(W), .START_X(0), .START_Y(0), .STEP_DIV(STEP)) dut (
    .clk(clk), .rst(rst), .move_in(move_in), .move_valid(move_valid),
    .solved(solved), .failed(failed), .clear(clear),
    .pos_x(pos_x), .pos_y(pos_y), .pos_valid(pos_valid), .pos_ready(pos_ready),
    .path_len(path_len), .busy(busy), .replay_done(replay_done),
    .fail_out(fail_out), .overflow(overflow), .err_oob(err_oob)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor: handshake log, hold and pacing rules -------
  bit           mon_en = 1'b0;
  bit           hs_pending = 1'b0;
  int           hs_cyc = 0, cyc = 0, valid_seen = 0;
  bit           prev_v = 1'b0, prev_acc = 1'b0;
  logic [W-1:0] prev_x = '0, prev_y = '0;
  int           got_x[$], got_y[$];

  always @(posedge clk) begin
    cyc++;
    if (mon_en) begin
      if (pos_valid) valid_seen++;
      if (prev_v && !prev_acc) begin
        chk("hold_valid", pos_valid, 1);
        chk("hold_x", pos_x, prev_x);
        chk("hold_y", pos_y, prev_y);
      end
      if (pos_valid && !prev_v && hs_pending) begin
        chk("pace_gap", cyc - hs_cyc, STEP);
        hs_pending = 1'b0;
      end
      if (pos_valid && pos_ready) begin
        got_x.push_back(int'(pos_x));
        got_y.push_back(int'(pos_y));
        hs_pending = 1'b1;
        hs_cyc = cyc;
      end
    end
    prev_v   = pos_valid;
    prev_acc = pos_valid && pos_ready;
    prev_x   = pos_x;
    prev_y   = pos_y;
  end

  // ---------------- reference model -------------------------------------
  logic [1:0] stim_q[$];
  int         exp_x[$], exp_y[$];
  bit         exp_oob;

  // Walk the stored moves (first DEPTH) from the entry cell, stopping at
  // the first step that would leave 0..MAXC.
  function automatic void build_model();
    int x, y, nx, ny, lim;
    exp_x.delete(); exp_y.delete(); exp_oob = 1'b0;
    x = 0; y = 0;
    exp_x.push_back(x); exp_y.push_back(y);
    lim = (stim_q.size() > DEPTH) ? DEPTH : stim_q.size();
    for (int i = 0; i < lim; i++) begin
      nx = x; ny = y;
      case (stim_q[i])
        2'd0:    ny = y - 1;
        2'd1:    nx = x + 1;
        2'd2:    nx = x - 1;
        default: ny = y + 1;
      endcase
      if (nx < 0 || nx > MAXC || ny < 0 || ny > MAXC) begin
        exp_oob = 1'b1;
        break;
      end
      x = nx; y = ny;
      exp_x.push_back(x); exp_y.push_back(y);
    end
  endfunction

  // ---------------- generic capture + replay run ------------------------
  bit stalled;
  int stall_left;

  // mode 0: ready always high; 1: random ready; 2: 10-cycle stall at (1,0)
  task automatic run_replay(input int mode);
    int  n;
    bit  fin;
    got_x.delete(); got_y.delete();
    hs_pending = 1'b0;
    build_model();
    n = stim_q.size();
    foreach (stim_q[i]) begin
      move_in = stim_q[i]; move_valid = 1'b1;
      tick();
      chk("busy_capture", busy, 1);
    end
    move_valid = 1'b0; move_in = 2'b00;
    chk("overflow", overflow, (n > DEPTH) ? 1 : 0);
    chk("path_len", path_len, (n > DEPTH) ? DEPTH : n);
    solved = 1'b1; tick(); solved = 1'b0;
    chk("busy_replay", busy, 1);
    stalled = 1'b0; stall_left = 0;
    for (int c = 0; c < 3000; c++) begin
      if (replay_done || fail_out) break;
      case (mode)
        1: pos_ready = 1'($urandom_range(0, 1));
        2: begin
          if (!stalled && pos_valid && pos_x == 5'd1 && pos_y == 5'd0) begin
            stalled = 1'b1; stall_left = 10;
          end
          if (stall_left > 0) begin pos_ready = 1'b0; stall_left--; end
          else pos_ready = 1'b1;
        end
        default: pos_ready = 1'b1;
      endcase
      tick();
    end
    fin = replay_done || fail_out;
    chk("timeout", fin, 1);
    pos_ready = 1'b0;
    chk("coord_count", got_x.size(), exp_x.size());
    for (int i = 0; i < got_x.size() && i < exp_x.size(); i++) begin
      chk("coord_x", got_x[i], exp_x[i]);
      chk("coord_y", got_y[i], exp_y[i]);
    end
    chk("err_oob", err_oob, exp_oob);
    chk("fail_out", fail_out, exp_oob);
    chk("replay_done", replay_done, !exp_oob);
    chk("valid_after", pos_valid, 0);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clr_len", path_len, 0);
    chk("clr_ovf", overflow, 0);
    chk("clr_oob", err_oob, 0);
    chk("clr_state", replay_done || fail_out || busy, 0);
  endtask

  // ---------------- table ------------------------------------------------
  typedef struct {
    logic [15:0] mv;      // move i in bits [2i+1:2i]
    int          n;
    int          ncoord;
    int          fx;
    int          fy;
    bit          oob;
  } vec_t;
  vec_t tv[7];

  initial begin
    tv[0] = '{16'h00F5, 4, 5, 2, 2, 1'b0};  // R,R,D,D
    tv[1] = '{16'h0000, 0, 1, 0, 0, 1'b0};  // empty path
    tv[2] = '{16'h0000, 1, 1, 0, 0, 1'b1};  // U from (0,0)
    tv[3] = '{16'h0002, 1, 1, 0, 0, 1'b1};  // L from (0,0)
    tv[4] = '{16'h001F, 4, 5, 1, 1, 1'b0};  // D,D,R,U
    tv[5] = '{16'h0029, 3, 3, 0, 0, 1'b1};  // R,L,L -> oob on third
    tv[6] = '{16'h007F, 4, 5, 1, 3, 1'b0};  // D,D,D,R

    // reset state
    #2;
    chk("rst_valid", pos_valid, 0);
    chk("rst_x", pos_x, 0);
    chk("rst_y", pos_y, 0);
    chk("rst_len", path_len, 0);
    chk("rst_flags", {busy, replay_done, fail_out, overflow, err_oob}, 0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    mon_en = 1'b1;

    // table-driven paths
    for (int k = 0; k < 7; k++) begin
      stim_q.delete();
      for (int i = 0; i < tv[k].n; i++) stim_q.push_back(tv[k].mv[2*i +: 2]);
      got_x.delete();
      run_replay(0);
      chk("tv_ncoord", got_x.size(), tv[k].ncoord);
      if (got_x.size() > 0) begin
        chk("tv_fx", got_x[got_x.size()-1], tv[k].fx);
        chk("tv_fy", got_y[got_y.size()-1], tv[k].fy);
      end
      chk("tv_oob_model", exp_oob, tv[k].oob);
    end

    // back-pressure stall at (1,0)
    stim_q = '{2'b01, 2'b01, 2'b11, 2'b11};
    run_replay(2);
    chk("stall_seen", stalled, 1);

    // failed during capture
    for (int i = 0; i < 3; i++) begin
      move_in = 2'b01; move_valid = 1'b1; tick();
    end
    move_valid = 1'b0; failed = 1'b1; tick(); failed = 1'b0;
    chk("fail_out_set", fail_out, 1);
    chk("fail_busy", busy, 0);
    chk("fail_len", path_len, 3);
    valid_seen = 0;
    solved = 1'b1; repeat (6) tick(); solved = 1'b0;
    chk("fail_no_valid", valid_seen, 0);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("fail_clr_len", path_len, 0);
    chk("fail_clr_out", fail_out, 0);

    // overflow: 65 alternating R/L moves
    stim_q.delete();
    for (int i = 0; i < DEPTH + 1; i++) stim_q.push_back((i % 2 == 0) ? 2'b01 : 2'b10);
    run_replay(0);
    chk("ovf_coords", got_x.size(), DEPTH + 1);

    // randomized paths with random back-pressure
    for (int r = 0; r < 25; r++) begin
      int n;
      n = $urandom_range(0, 12);
      stim_q.delete();
      for (int i = 0; i < n; i++) begin
        int p;
        p = $urandom_range(0, 9);
        stim_q.push_back(p < 3 ? 2'b01 : p < 6 ? 2'b11 : p < 8 ? 2'b00 : 2'b10);
      end
      run_replay(1);
    end

    // empty path: exact timing of first valid and replay_done
    pos_ready = 1'b1; solved = 1'b1; tick(); solved = 1'b0;
    chk("empty_busy", busy, 1);
    chk("empty_valid0", pos_valid, 0);
    tick();
    chk("empty_valid1", pos_valid, 1);
    chk("empty_xy", {pos_x, pos_y}, 0);
    tick();
    chk("empty_done", replay_done, 1);
    chk("empty_valid2", pos_valid, 0);
    pos_ready = 1'b0;
    clear = 1'b1; tick(); clear = 1'b0;

    // asynchronous reset mid-replay
    move_in = 2'b01; move_valid = 1'b1; tick();
    move_in = 2'b11; tick();
    move_valid = 1'b0; solved = 1'b1; tick(); solved = 1'b0;
    for (int c = 0; c < 20 && !pos_valid; c++) tick();
    chk("pre_rst_valid", pos_valid, 1);
    mon_en = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", pos_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_len", path_len, 0);
    chk("arst_xy", {pos_x, pos_y}, 0);
    rst = 1'b1;
    tick();
    chk("post_rst_state", {busy, replay_done, fail_out}, 0);
    move_in = 2'b01; move_valid = 1'b1; tick(); move_valid = 1'b0;
    chk("post_rst_busy", busy, 1);
    chk("post_rst_len", path_len, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
